// File: rtl/psum_ppu_if.sv
// psum_ppu_if: bundles the psum_ppu handshake and data signals.
//   psum channel : psum_valid/psum_ready/psum_data/psum_last plus psum_fb
//                  (bank contents fed back to mac_16.partial_sum_in)
//   tile config  : scale_mult, scale_shift, relu_en (sampled on last-beat accept)
//   out channel  : out_valid/out_ready/out_data/sat_flag
//   status       : busy
// Modports: slave = psum_ppu side, master = upstream/writeback side.
// Parameters must match those given to the psum_ppu instance.
interface psum_ppu_if #(
  parameter int LANES  = 16,
  parameter int PSUM_W = 24,
  parameter int OUT_W  = 8,
  parameter int MULT_W = 16
) ();
  logic                      psum_valid;
  logic                      psum_ready;
  logic [LANES*PSUM_W-1:0]   psum_data;
  logic                      psum_last;
  logic [LANES*PSUM_W-1:0]   psum_fb;
  logic [MULT_W-1:0]         scale_mult;
  logic [4:0]                scale_shift;
  logic                      relu_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*OUT_W-1:0]    out_data;
  logic                      sat_flag;
  logic                      busy;

  modport slave (
    input  psum_valid, psum_data, psum_last, scale_mult, scale_shift, relu_en,
           out_ready,
    output psum_ready, psum_fb, out_valid, out_data, sat_flag, busy
  );

  modport master (
    output psum_valid, psum_data, psum_last, scale_mult, scale_shift, relu_en,
           out_ready,
    input  psum_ready, psum_fb, out_valid, out_data, sat_flag, busy
  );
endinterface

// File: rtl/psum_ppu.sv
// psum_ppu: partial-sum bank and int8 requantizer downstream of mac_16.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : psum_ppu_if.slave
//     - psum beats overwrite the bank (mac_16 has already added psum_fb)
//     - on the last beat, the tile is requantized LANES_PER_CYCLE lanes per
//       clock: (acc * mult + round) >>> shift, optional ReLU, int8 saturation
//     - the result is held on out_data until the out handshake, which also
//       clears the bank for the next tile
module psum_ppu #(
  parameter int LANES           = 16,
  parameter int PSUM_W          = 24,
  parameter int OUT_W           = 8,
  parameter int MULT_W          = 16,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  psum_ppu_if.slave  bus
);

  localparam int GROUPS = LANES / LANES_PER_CYCLE;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PROD_W = PSUM_W + MULT_W + 1;

  localparam logic signed [PROD_W-1:0] QMAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] QMIN = PROD_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {ACCUM, QUANT, OUT} state_t;

  state_t state, state_next;

  logic [LANES-1:0][PSUM_W-1:0] bank;
  logic [LANES-1:0][OUT_W-1:0]  out_reg;
  logic [GW-1:0]                grp;
  logic [MULT_W-1:0]            mult_q;
  logic [4:0]                   shift_q;
  logic                         relu_q;
  logic                         sat_q;

  logic psum_ready, out_valid, busy;
  logic accept, out_fire, last_grp;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  assign last_grp = (grp == GW'(GROUPS - 1));

  always_comb begin
    state_next = state;
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ACCUM: begin
        psum_ready = 1'b1;
        busy       = 1'b0;
        if (bus.psum_valid && bus.psum_last) state_next = QUANT;
      end
      QUANT: begin
        if (last_grp) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  assign accept   = bus.psum_valid && psum_ready;
  assign out_fire = out_valid && bus.out_ready;

  // ---------------- requantizer (one lane group) ----------------
  logic [LANES_PER_CYCLE-1:0][OUT_W-1:0] q_lane;
  logic [LANES_PER_CYCLE-1:0]            q_sat;
  logic [LW-1:0]                         q_idx [LANES_PER_CYCLE];
  logic [PSUM_W-1:0]                     acc;
  logic signed [PROD_W-1:0]              prod, res;
  logic [PROD_W-1:0]                     rnd;

  always_comb begin
    acc  = '0;
    prod = '0;
    res  = '0;
    rnd  = '0;
    for (int unsigned k = 0; k < LANES_PER_CYCLE; k++) begin
      q_idx[k] = LW'(32'(grp) * LANES_PER_CYCLE + k);
      acc      = bank[q_idx[k]];
      // Signed accumulator times zero-extended unsigned multiplier.
      prod = $signed({{(MULT_W + 1){acc[PSUM_W-1]}}, acc}) *
             $signed({{PSUM_W{1'b0}}, 1'b0, mult_q});
      if (shift_q != 5'd0) begin
        rnd = PROD_W'(1) << (shift_q - 5'd1);
        res = (prod + $signed(rnd)) >>> shift_q;
      end else begin
        rnd = '0;
        res = prod;
      end
      if (relu_q && res[PROD_W-1]) res = '0;
      q_sat[k] = 1'b0;
      if (res > QMAX) begin
        q_lane[k] = QMAX[OUT_W-1:0];
        q_sat[k]  = 1'b1;
      end else if (res < QMIN) begin
        q_lane[k] = QMIN[OUT_W-1:0];
        q_sat[k]  = 1'b1;
      end else begin
        q_lane[k] = res[OUT_W-1:0];
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bank    <= '0;
      out_reg <= '0;
      grp     <= '0;
      mult_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      if (accept) begin
        bank <= bus.psum_data;
        if (bus.psum_last) begin
          mult_q  <= bus.scale_mult;
          shift_q <= bus.scale_shift;
          relu_q  <= bus.relu_en;
          sat_q   <= 1'b0;
          grp     <= '0;
        end
      end
      if (state == QUANT) begin
        for (int unsigned k = 0; k < LANES_PER_CYCLE; k++)
          out_reg[q_idx[k]] <= q_lane[k];
        sat_q <= sat_q | (|q_sat);
        grp   <= grp + 1'b1;
      end
      if (out_fire) bank <= '0;
    end
  end

  assign bus.psum_ready = psum_ready;
  assign bus.psum_fb    = bank;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_reg;
  assign bus.sat_flag   = sat_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_psum_ppu.sv
// tb_psum_ppu: directed bench for psum_ppu with a scoreboard of expected tiles.
module tb_psum_ppu;
  localparam int LANES  = 16;
  localparam int PSUM_W = 24;
  localparam int OUT_W  = 8;
  localparam int MULT_W = 16;
  localparam int LPC    = 4;
  localparam int CW     = LANES * PSUM_W;

  typedef int lanes_t [LANES];
  typedef struct packed {
    logic [LANES*OUT_W-1:0] data;
    logic                   sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_ppu_if #(.LANES(LANES), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .MULT_W(MULT_W)) bus_if ();

  psum_ppu #(
    .LANES(LANES), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .MULT_W(MULT_W), .LANES_PER_CYCLE(LPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  exp_t            sb[$];
  int              n_cmp  = 0;
  int              n_fail = 0;
  logic [CW-1:0]   last_d;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lanes_t all_lanes(input int x);
    lanes_t v;
    for (int i = 0; i < LANES; i++) v[i] = x;
    return v;
  endfunction

  // Reference requantizer in wide integer arithmetic.
  function automatic exp_t model(input lanes_t vals, input int mult, input int shift, input bit relu);
    exp_t   e;
    longint p, r;
    e.sat  = 1'b0;
    e.data = '0;
    for (int i = 0; i < LANES; i++) begin
      p = longint'(vals[i]) * longint'(mult);
      if (shift > 0) r = (p + (longint'(1) << (shift - 1))) >>> shift;
      else           r = p;
      if (relu && r < 0) r = 0;
      if (r > 127)       begin r = 127;  e.sat = 1'b1; end
      else if (r < -128) begin r = -128; e.sat = 1'b1; end
      e.data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send_beat(input lanes_t vals, input bit last, input int mult,
                           input int shift, input bit relu);
    logic [CW-1:0] d;
    int            w;
    for (int i = 0; i < LANES; i++) d[i*PSUM_W +: PSUM_W] = PSUM_W'(vals[i]);
    w = 0;
    while (!bus_if.psum_ready && w < 50) begin @(posedge clk); #1; w++; end
    check("ready_before_beat", CW'(bus_if.psum_ready), CW'(1'b1));
    bus_if.psum_valid  = 1'b1;
    bus_if.psum_data   = d;
    bus_if.psum_last   = last;
    bus_if.scale_mult  = MULT_W'(mult);
    bus_if.scale_shift = 5'(shift);
    bus_if.relu_en     = relu;
    @(posedge clk); #1;
    bus_if.psum_valid  = 1'b0;
    bus_if.psum_last   = 1'b0;
    // Scramble config: only the values sampled at accept may matter.
    bus_if.scale_mult  = MULT_W'($urandom);
    bus_if.scale_shift = 5'($urandom);
    bus_if.relu_en     = 1'($urandom);
    last_d = d;
    check("fb_after_accept", bus_if.psum_fb, d);
    if (last) sb.push_back(model(vals, mult, shift, relu));
  endtask

  // Waits for out_valid (bounded), checks latency and the tile, and if
  // out_ready is high checks the post-handshake state.
  task automatic collect(input string tag);
    int   c;
    exp_t e;
    check({tag, "_busy"}, CW'(bus_if.busy), CW'(1'b1));
    check({tag, "_ready_low"}, CW'(bus_if.psum_ready), CW'(1'b0));
    c = 0;
    while (!bus_if.out_valid && c < 20) begin @(posedge clk); #1; c++; end
    check({tag, "_latency"}, CW'(c), CW'(LANES / LPC));
    if (bus_if.out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, CW'(bus_if.out_data), CW'(e.data));
      check({tag, "_sat"}, CW'(bus_if.sat_flag), CW'(e.sat));
    end else begin
      check({tag, "_out_seen"}, CW'(bus_if.out_valid), CW'(1'b1));
    end
    if (bus_if.out_ready) begin
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, CW'(bus_if.out_valid), CW'(1'b0));
      check({tag, "_ready_back"}, CW'(bus_if.psum_ready), CW'(1'b1));
      check({tag, "_bank_clear"}, bus_if.psum_fb, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    lanes_t v;
    exp_t   e;
    logic [LANES*OUT_W-1:0] held;
    logic                   held_sat;

    bus_if.psum_valid  = 1'b0;
    bus_if.psum_data   = '0;
    bus_if.psum_last   = 1'b0;
    bus_if.scale_mult  = '0;
    bus_if.scale_shift = '0;
    bus_if.relu_en     = 1'b0;
    bus_if.out_ready   = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", CW'(bus_if.out_valid), CW'(1'b0));
    check("rst_psum_fb", bus_if.psum_fb, '0);
    check("rst_out_data", CW'(bus_if.out_data), '0);
    check("rst_sat", CW'(bus_if.sat_flag), CW'(1'b0));
    check("rst_busy", CW'(bus_if.busy), CW'(1'b0));
    check("rst_psum_ready", CW'(bus_if.psum_ready), CW'(1'b1));

    // Single pass, 516 >> 3 rounded = 65
    send_beat(all_lanes(516), 1'b1, 1, 3, 1'b0);
    collect("t516_s3");
    // 516 >> 2 = 129 saturates to 127
    send_beat(all_lanes(516), 1'b1, 1, 2, 1'b0);
    collect("t516_s2");
    // Two passes: 300*3/16 = 56.25 -> 56
    send_beat(all_lanes(100), 1'b0, 1, 0, 1'b0);
    check("pass1_ready", CW'(bus_if.psum_ready), CW'(1'b1));
    send_beat(all_lanes(300), 1'b1, 3, 4, 1'b0);
    collect("two_pass");
    // ReLU on/off with one negative lane
    v = all_lanes(40); v[0] = -40;
    send_beat(v, 1'b1, 1, 0, 1'b1);
    collect("relu_on");
    send_beat(v, 1'b1, 1, 0, 1'b0);
    collect("relu_off");
    // Negative saturation and negative half rounding toward +inf
    send_beat(all_lanes(-1000), 1'b1, 1, 0, 1'b0);
    collect("neg_sat");
    send_beat(all_lanes(-24), 1'b1, 1, 4, 1'b0);
    collect("neg_round");
    // Extreme magnitude with maximum shift
    v = all_lanes(8388607); v[5] = -8388608; v[9] = 0;
    send_beat(v, 1'b1, 65535, 31, 1'b0);
    collect("max_shift");
    // Random tiles exercise the per-lane mapping
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < LANES; i++) v[i] = $signed(24'($urandom)) >>> $urandom_range(0, 16);
      send_beat(v, 1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)), 1'($urandom));
      collect("rand");
    end

    // Backpressure: hold for 6 cycles, a stray psum_valid is ignored
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < LANES; i++) v[i] = i * 37 - 200;
    send_beat(v, 1'b1, 5, 3, 1'b0);
    e = sb[0];
    collect("bp");
    held     = bus_if.out_data;
    held_sat = bus_if.sat_flag;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        bus_if.psum_valid = 1'b1;
        bus_if.psum_last  = 1'b1;
        bus_if.psum_data  = {LANES{24'h000123}};
      end
      @(posedge clk); #1;
      bus_if.psum_valid = 1'b0;
      bus_if.psum_last  = 1'b0;
      check("bp_data_hold", CW'(bus_if.out_data), CW'(e.data));
      check("bp_sat_hold", CW'(bus_if.sat_flag), CW'(e.sat));
      check("bp_valid_hold", CW'(bus_if.out_valid), CW'(1'b1));
      check("bp_psum_ready", CW'(bus_if.psum_ready), CW'(1'b0));
    end
    check("bp_stray_ignored", bus_if.psum_fb, last_d);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_single_hs", CW'(bus_if.out_valid), CW'(1'b0));
    check("bp_bank_clear", bus_if.psum_fb, '0);
    check("bp_ready_back", CW'(bus_if.psum_ready), CW'(1'b1));

    // Reset during QUANT g=2 aborts the tile
    send_beat(all_lanes(516), 1'b1, 1, 3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_out_valid", CW'(bus_if.out_valid), CW'(1'b0));
    check("abort_psum_fb", bus_if.psum_fb, '0);
    check("abort_busy", CW'(bus_if.busy), CW'(1'b0));
    check("abort_out_data", CW'(bus_if.out_data), '0);
    check("abort_ready", CW'(bus_if.psum_ready), CW'(1'b1));
    // Fresh tile after abort
    send_beat(all_lanes(100), 1'b0, 1, 0, 1'b0);
    send_beat(all_lanes(300), 1'b1, 3, 4, 1'b0);
    collect("post_abort");

    check("sb_empty", CW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
